// File: rtl/rotating_pattern_matcher_pkg.sv
// Shared types and helpers for the rotating pattern matcher: FSM states,
// character rotation, mask expansion and lowest-set-bit encoding.
package rotating_pattern_matcher_pkg;

    // Widest data word the helpers handle; callers zero-extend into this.
    localparam int unsigned RPM_MAX_W = 512;
    localparam int unsigned RPM_IDX_W = $clog2(RPM_MAX_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        ARMED = 2'd2
    } rpm_state_t;

    // Rotate the low `width` bits of value right by `chars` characters.
    function automatic logic [RPM_MAX_W-1:0] rotr_chars(
        input logic [RPM_MAX_W-1:0] value,
        input int unsigned          width,
        input int unsigned          char_width,
        input int unsigned          chars
    );
        logic [RPM_MAX_W-1:0] result;
        int unsigned          amount;
        result = '0;
        amount = (char_width * chars) % width;
        for (int unsigned i = 0; i < RPM_MAX_W; i++) begin
            if (i < width) begin
                result[RPM_IDX_W'(i)] = value[RPM_IDX_W'((i + amount) % width)];
            end
        end
        return result;
    endfunction

    // Widen a per-character mask so each bit covers char_width data bits.
    function automatic logic [RPM_MAX_W-1:0] expand_mask(
        input logic [RPM_MAX_W-1:0] mask,
        input int unsigned          num_chars,
        input int unsigned          char_width
    );
        logic [RPM_MAX_W-1:0] result;
        result = '0;
        for (int unsigned i = 0; i < RPM_MAX_W; i++) begin
            if (i < num_chars * char_width) begin
                result[RPM_IDX_W'(i)] = mask[RPM_IDX_W'(i / char_width)];
            end
        end
        return result;
    endfunction

    // Index of the lowest set bit among the low `width` bits; 0 when none.
    function automatic int unsigned lowest_set(
        input logic [RPM_MAX_W-1:0] vec,
        input int unsigned          width
    );
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < RPM_MAX_W; i++) begin
            if (i < width && vec[RPM_IDX_W'(i)] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rotating_pattern_matcher_compare_stage.sv
// S1 compare bank: one masked comparator per rotation, registered behind a
// valid/ready handshake.
module rpm_compare_stage
    import rotating_pattern_matcher_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned CHAR_WIDTH = 8,
    localparam int unsigned NUM_ROT    = DATA_WIDTH / CHAR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_ROT*DATA_WIDTH-1:0] rot_flat,
    input  logic [NUM_ROT*NUM_ROT-1:0]    msk_flat,
    input  logic                          next_ready,
    output logic                          s1_valid,
    output logic                          s1_advance,
    output logic [NUM_ROT-1:0]            s1_hit
);

    logic [NUM_ROT-1:0] hit_comb;
    logic               accept;

    assign s1_advance = s1_valid & next_ready;
    assign in_ready   = enable & (~s1_valid | s1_advance);
    assign accept     = in_valid & in_ready;

    for (genvar k = 0; k < NUM_ROT; k++) begin : g_cmp
        logic [DATA_WIDTH-1:0] care;
        assign care = DATA_WIDTH'(expand_mask(
            RPM_MAX_W'(msk_flat[k*NUM_ROT +: NUM_ROT]), NUM_ROT, CHAR_WIDTH));
        assign hit_comb[k] =
            ((in_data ^ rot_flat[k*DATA_WIDTH +: DATA_WIDTH]) & care) == '0;
    end

    // Capture the hit vector on acceptance; empty the stage once it hands off.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_hit   <= hit_comb;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rotating_pattern_matcher.sv
// Rotating pattern matcher: builds all character rotations of a loaded
// pattern, then matches streamed words against every rotation in a two-stage
// pipeline, reporting hit vector, first-hit index and a saturating hit count.
module rotating_pattern_matcher
    import rotating_pattern_matcher_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 64,
    parameter  int unsigned CHAR_WIDTH  = 8,
    parameter  int unsigned COUNT_WIDTH = 32,
    localparam int unsigned NUM_ROT     = DATA_WIDTH / CHAR_WIDTH,
    localparam int unsigned IDX_WIDTH   = (NUM_ROT > 1) ? $clog2(NUM_ROT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  pattern_in,
    input  logic [NUM_ROT-1:0]     mask_in,
    input  logic                   pattern_load,
    output logic                   pattern_ready,
    output logic                   armed,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_ROT-1:0]     out_match_vec,
    output logic                   out_match_any,
    output logic [IDX_WIDTH-1:0]   out_match_idx,
    output logic [COUNT_WIDTH-1:0] hit_count,
    input  logic                   hit_clear
);

    rpm_state_t                    state;
    logic [IDX_WIDTH-1:0]          build_cnt;
    logic [DATA_WIDTH-1:0]         rot [NUM_ROT];
    logic [NUM_ROT-1:0]            msk [NUM_ROT];
    logic [NUM_ROT*DATA_WIDTH-1:0] rot_flat;
    logic [NUM_ROT*NUM_ROT-1:0]    msk_flat;
    logic [DATA_WIDTH-1:0]         rot_next;
    logic [NUM_ROT-1:0]            msk_next;
    logic                          s1_valid;
    logic                          s1_advance;
    logic [NUM_ROT-1:0]            s1_hit;
    logic                          s2_ready;
    logic                          load_accept;

    assign pattern_ready = ~s1_valid & ~out_valid;
    assign load_accept   = pattern_load & pattern_ready;
    assign armed         = (state == ARMED);
    assign s2_ready      = ~out_valid | out_ready;

    for (genvar k = 0; k < NUM_ROT; k++) begin : g_flat
        assign rot_flat[k*DATA_WIDTH +: DATA_WIDTH] = rot[k];
        assign msk_flat[k*NUM_ROT +: NUM_ROT]       = msk[k];
    end

    // Next rotation is one character (one mask bit) beyond the last one written.
    always_comb begin
        rot_next = DATA_WIDTH'(rotr_chars(RPM_MAX_W'(rot[build_cnt - 1'b1]),
                                          DATA_WIDTH, CHAR_WIDTH, 1));
        msk_next = NUM_ROT'(rotr_chars(RPM_MAX_W'(msk[build_cnt - 1'b1]),
                                       NUM_ROT, 1, 1));
    end

    // FSM and rotation storage: a load seeds rot[0], BUILD fills one entry per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            build_cnt <= '0;
            for (int unsigned k = 0; k < NUM_ROT; k++) begin
                rot[k] <= '0;
                msk[k] <= '0;
            end
        end else if (load_accept) begin
            rot[0]    <= pattern_in;
            msk[0]    <= mask_in;
            build_cnt <= IDX_WIDTH'(1);
            if (NUM_ROT == 1) begin
                state <= ARMED;
            end else begin
                state <= BUILD;
            end
        end else if (state == BUILD) begin
            rot[build_cnt] <= rot_next;
            msk[build_cnt] <= msk_next;
            build_cnt      <= build_cnt + 1'b1;
            if (build_cnt == IDX_WIDTH'(NUM_ROT - 1)) begin
                state <= ARMED;
            end
        end
    end

    rpm_compare_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHAR_WIDTH (CHAR_WIDTH)
    ) u_s1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (armed),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rot_flat   (rot_flat),
        .msk_flat   (msk_flat),
        .next_ready (s2_ready),
        .s1_valid   (s1_valid),
        .s1_advance (s1_advance),
        .s1_hit     (s1_hit)
    );

    // S2 output stage: vector, OR-reduction and lowest-index encode, held under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_match_vec <= '0;
            out_match_any <= 1'b0;
            out_match_idx <= '0;
        end else if (s1_advance) begin
            out_valid     <= 1'b1;
            out_match_vec <= s1_hit;
            out_match_any <= |s1_hit;
            out_match_idx <= IDX_WIDTH'(lowest_set(RPM_MAX_W'(s1_hit), NUM_ROT));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of transferred hits; clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
        end else if (hit_clear) begin
            hit_count <= '0;
        end else if (out_valid && out_ready && out_match_any && hit_count != '1) begin
            hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rotating_pattern_matcher.sv
// Randomised + directed bench for rotating_pattern_matcher with a
// character-level reference model and in-order scoreboard.
module tb_rotating_pattern_matcher;

    localparam int NR = 8;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        reset, pattern_load, in_valid, out_ready, hit_clear;
    logic [63:0] pattern_in, in_data;
    logic [7:0]  mask_in;
    logic        pattern_ready, armed, in_ready, out_valid, out_match_any;
    logic [7:0]  out_match_vec;
    logic [2:0]  out_match_idx;
    logic [31:0] hit_count;
    logic        s_pattern_ready, s_armed, s_in_ready, s_out_valid, s_out_match_any;
    logic [7:0]  s_out_match_vec;
    logic [2:0]  s_out_match_idx;
    logic [3:0]  sat_hit_count;

    always #5 clk = ~clk;

    rotating_pattern_matcher u_dut (
        .clk(clk), .reset(reset), .pattern_in(pattern_in), .mask_in(mask_in),
        .pattern_load(pattern_load), .pattern_ready(pattern_ready), .armed(armed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_match_vec(out_match_vec),
        .out_match_any(out_match_any), .out_match_idx(out_match_idx),
        .hit_count(hit_count), .hit_clear(hit_clear)
    );

    rotating_pattern_matcher #(.COUNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .pattern_in(pattern_in), .mask_in(mask_in),
        .pattern_load(pattern_load), .pattern_ready(s_pattern_ready), .armed(s_armed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_match_vec(s_out_match_vec),
        .out_match_any(s_out_match_any), .out_match_idx(s_out_match_idx),
        .hit_count(sat_hit_count), .hit_clear(hit_clear)
    );

    typedef struct packed {
        logic [7:0] vec;
        logic       any;
        logic [2:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mdl_pat;
    logic [7:0]  mdl_msk;
    logic [31:0] mdl_cnt;
    logic [3:0]  mdl_cnt4;
    int          n_checks, n_fails, n_delivered;
    bit          mon_on;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Rotation k matches when every enabled character j of the word equals
    // character (j+k) mod NR of the pattern.
    function automatic exp_t model_match(input logic [63:0] p, input logic [7:0] m,
                                         input logic [63:0] d);
        exp_t e;
        e.vec = '0;
        for (int k = 0; k < NR; k++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < NR; j++) begin
                int c;
                c = (j + k) % NR;
                if (m[c] && d[j*CW +: CW] != p[c*CW +: CW]) ok = 1'b0;
            end
            e.vec[k] = ok;
        end
        e.any = |e.vec;
        e.idx = '0;
        for (int k = NR - 1; k >= 0; k--) if (e.vec[k]) e.idx = 3'(k);
        return e;
    endfunction

    function automatic logic [63:0] make_word(input logic [63:0] p, input int k);
        logic [63:0] w;
        for (int j = 0; j < NR; j++) w[j*CW +: CW] = p[((j + k) % NR)*CW +: CW];
        return w;
    endfunction

    // Scoreboard and counter model, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin
        if (mon_on) begin : mon
            logic hit;
            hit = 1'b0;
            check_eq("hit_count", hit_count, mdl_cnt);
            check_eq("hit_count_w4", sat_hit_count, mdl_cnt4);
            if (reset) begin
                exp_q.delete();
                mdl_cnt  = '0;
                mdl_cnt4 = '0;
                mdl_pat  = '0;
                mdl_msk  = '0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("out_valid_spurious", out_valid, 0);
                    end else begin
                        check_eq("match_vec", out_match_vec, exp_q[0].vec);
                        check_eq("match_any", out_match_any, exp_q[0].any);
                        check_eq("match_idx", out_match_idx, exp_q[0].idx);
                        if (out_ready) begin
                            hit = exp_q[0].any;
                            void'(exp_q.pop_front());
                            n_delivered++;
                        end
                    end
                end
                if (hit_clear) begin
                    mdl_cnt  = '0;
                    mdl_cnt4 = '0;
                end else if (hit) begin
                    if (mdl_cnt != '1) mdl_cnt = mdl_cnt + 1;
                    if (mdl_cnt4 != '1) mdl_cnt4 = mdl_cnt4 + 1;
                end
                if (in_valid && in_ready) exp_q.push_back(model_match(mdl_pat, mdl_msk, in_data));
                if (pattern_load && pattern_ready) begin
                    mdl_pat = pattern_in;
                    mdl_msk = mask_in;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [63:0] p, input logic [7:0] m);
        int unsigned n;
        n = 0;
        pattern_in   = p;
        mask_in      = m;
        pattern_load = 1'b1;
        @(negedge clk);
        while (!pattern_ready && n < 50) begin
            step();
            @(negedge clk);
            n++;
        end
        if (!pattern_ready) check_eq("load_timeout", pattern_ready, 1);
        step();
        pattern_load = 1'b0;
    endtask

    task automatic wait_armed();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!armed && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        check_eq("armed_wait", armed, 1);
        step();
    endtask

    task automatic push_word(input logic [63:0] d);
        int unsigned n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            step();
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Pipeline must be empty and out_ready high on entry.
    task automatic word_latency(input logic [63:0] d, input logic [7:0] vec, input logic [2:0] idx);
        push_word(d);
        @(negedge clk);
        check_eq("lat_n1_valid", out_valid, 0);
        step();
        @(negedge clk);
        check_eq("lat_n2_valid", out_valid, 1);
        check_eq("lat_vec", out_match_vec, vec);
        check_eq("lat_any", out_match_any, |vec);
        check_eq("lat_idx", out_match_idx, idx);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p1;
        p1           = 64'h0102030405060708;
        reset        = 1'b1;
        pattern_load = 1'b0;
        pattern_in   = '0;
        mask_in      = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        hit_clear    = 1'b0;
        n_checks     = 0;
        n_fails      = 0;
        n_delivered  = 0;
        mdl_pat      = '0;
        mdl_msk      = '0;
        mdl_cnt      = '0;
        mdl_cnt4     = '0;
        mon_on       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(negedge clk);
        check_eq("rst_armed", armed, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_pattern_ready", pattern_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_vec", out_match_vec, 0);
        check_eq("rst_any", out_match_any, 0);
        check_eq("rst_idx", out_match_idx, 0);
        check_eq("rst_hit_count", hit_count, 0);
        step();
        reset = 1'b0;

        // Build timing: 7 build cycles, armed on the 8th.
        load_pattern(p1, 8'hFF);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check_eq("armed_during_build", armed, 0);
            check_eq("in_ready_during_build", in_ready, 0);
            step();
        end
        @(negedge clk);
        check_eq("armed_after_build", armed, 1);
        step();

        word_latency(p1, 8'h01, 3'd0);
        word_latency(64'h0801020304050607, 8'h02, 3'd1);
        @(negedge clk);
        check_eq("hit_count_two", hit_count, 2);
        step();

        load_pattern(64'hAAAAAAAAAAAAAAAA, 8'hFF);
        wait_armed();
        word_latency(64'hAAAAAAAAAAAAAAAA, 8'hFF, 3'd0);
        word_latency(64'hFFFFFFFFFFFFFFFF, 8'h00, 3'd0);
        @(negedge clk);
        check_eq("hit_count_nomatch", hit_count, 3);
        step();

        load_pattern(64'h00000000000000AB, 8'h01);
        wait_armed();
        word_latency(64'h123456789ABCDEAB, 8'h01, 3'd0);

        load_pattern({$urandom, $urandom}, 8'h00);
        wait_armed();
        word_latency({$urandom, $urandom}, 8'hFF, 3'd0);

        // Reset mid-build discards the build.
        load_pattern(p1, 8'hFF);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_armed", armed, 0);
        check_eq("midrst_pattern_ready", pattern_ready, 1);
        check_eq("midrst_hit_count", hit_count, 0);
        repeat (8) step();
        @(negedge clk);
        check_eq("midrst_stays_idle", armed, 0);
        step();

        // Back-to-back stream with a 3-cycle output stall.
        load_pattern(p1, 8'hFF);
        wait_armed();
        begin
            logic [63:0] words[6];
            int sent, base, c;
            sent = 0;
            c    = 0;
            base = n_delivered;
            for (int i = 0; i < 6; i++) words[i] = make_word(p1, i);
            words[3][15:8] = words[3][15:8] ^ 8'h5A;
            while ((sent < 6 || exp_q.size() != 0) && c < 60) begin
                out_ready = !(c >= 3 && c <= 5);
                in_valid  = (sent < 6);
                in_data   = words[sent < 6 ? sent : 5];
                @(negedge clk);
                if (c == 4 || c == 5) check_eq("in_ready_stall", in_ready, 0);
                if (in_valid && in_ready) sent++;
                step();
                c++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check_eq("bp_delivered", n_delivered - base, 6);
        end

        // Saturation of the 4-bit counter.
        begin
            int sent, c;
            sent = 0;
            c    = 0;
            while (sent < 20 && c < 100) begin
                in_valid = 1'b1;
                in_data  = make_word(p1, $urandom_range(0, 7));
                @(negedge clk);
                if (in_valid && in_ready) sent++;
                step();
                c++;
            end
            in_valid = 1'b0;
            repeat (4) step();
            @(negedge clk);
            check_eq("hit_count_saturated", sat_hit_count, 15);
            step();
        end

        // Clear on the same cycle as a matching transfer.
        push_word(make_word(p1, 2));
        step();
        hit_clear = 1'b1;
        @(negedge clk);
        check_eq("clear_xfer_valid", out_valid, 1);
        step();
        hit_clear = 1'b0;
        @(negedge clk);
        check_eq("hit_count_cleared", hit_count, 0);
        check_eq("hit_count_w4_cleared", sat_hit_count, 0);
        step();

        // Randomised traffic with occasional reloads and clears.
        begin
            logic [63:0] rp, w;
            logic [7:0]  rm;
            logic        taken;
            rp = p1;
            for (int c = 0; c < 600; c++) begin
                w = make_word(rp, $urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 7)*8 +: 8] ^= 8'($urandom_range(1, 255));
                if ($urandom_range(0, 9) == 0) w = {$urandom, $urandom};
                in_data   = w;
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                hit_clear = ($urandom_range(0, 49) == 0);
                if (!pattern_load && $urandom_range(0, 59) == 0) begin
                    rp = {$urandom, $urandom};
                    if ($urandom_range(0, 1) == 0) rp = {4{rp[15:0]}};
                    rm = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) rm = 8'hFF;
                    pattern_in   = rp;
                    mask_in      = rm;
                    pattern_load = 1'b1;
                end
                @(negedge clk);
                taken = pattern_load && pattern_ready;
                step();
                if (taken) pattern_load = 1'b0;
            end
        end

        in_valid     = 1'b0;
        out_ready    = 1'b1;
        hit_clear    = 1'b0;
        pattern_load = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                step();
                n++;
            end
        end
        check_eq("drain_empty", exp_q.size(), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
